aes_key_expansion_multi: RTL and testbench
==========================================

// Module: aes_key_expansion_multi
// PURPOSE
//  Multi-mode AES key schedule: one core serves AES-128/192/256, selected per job by key_mode.
//  Generates one 32-bit schedule word per cycle using a single 4-byte S-box.
//  Streams the Nr+1 round keys (11/13/15) as 128-bit words over a valid/ready handshake.
//  Feeds the round-key input of the iterative AES cipher datapath.
// PARAMETERS
//  SUPPORT_192  1  0: key_mode 2'b01 is rejected like an illegal mode
//  SUPPORT_256  1  0: key_mode 2'b10 is rejected like an illegal mode
// PORTS
//  clk           in   1    clock, rising edge
//  reset         in   1    asynchronous, active-high; clears all state
//  start         in   1    job request; accepted only when start_ready=1
//  start_ready   out  1    1 when the FSM is in IDLE
//  key_mode      in   2    00=128, 01=192, 10=256, 11=illegal; sampled on accept
//  key           in   256  cipher key, left-aligned; 128-bit uses [255:128], 192-bit uses [255:64]
//  subkey        out  128  current round key, word w[4r] in [127:96]
//  subkey_valid  out  1    subkey, round_idx and last are valid
//  subkey_ready  in   1    consumer accepts; handshake = subkey_valid & subkey_ready
//  round_idx     out  4    round number r of the presented subkey
//  last          out  1    1 with the final round key of the job
//  busy          out  1    job in progress (FSM not IDLE)
//  mode_err      out  1    one-cycle pulse when start hits an illegal or disabled mode
// BEHAVIOUR
//  Reset values: every output 0 except start_ready=1. Internal word window, counters and Rcon cleared.
//  Nk = 4/6/8 and Nr = 10/12/14 per mode; word index i runs 0..4*(Nr+1)-1 (max 59).
//  Illegal start: pulses mode_err the next cycle; no state change; the FSM stays in IDLE.
//  Word rule (FIPS-197):
//    i<Nk: w[i] = key word i.
//    Else w[i] = w[i-Nk] ^ t, where t is:
//      SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i%Nk==0;
//      SubWord(w[i-1]) when Nk==8 and i%8==4;
//      w[i-1] otherwise.
//  Window: 8x32 shift register holding w[i-8..i-1]. w[i-Nk] is tapped per mode.
//  Rcon: a register starting at 8'h01 and advanced by xtime (x2 mod 0x11B) after each use.
//    Its use sequence is 01,02,04,...,80,1B,36.
//  i%Nk: a mod counter that wraps at Nk; no divider.
//  FSM:
//    IDLE --legal start--> GEN: latch key and key_mode; i=0.
//    GEN: one word per cycle into a 4-word accumulator. When 4 words are collected, move them to
//      the output register if it is empty or being handshaken this cycle. Otherwise stall word
//      generation; i and the window hold.
//    GEN --> DRAIN after w[4*Nr+3] is generated.
//    DRAIN --> IDLE on the handshake of last=1.
//  Timing:
//    Start accepted on edge E: first subkey_valid (round_idx=0, equal to key[255:128]) at E+4.
//    With subkey_ready held at 1, one key every 4 cycles; last key at E+4*(Nr+1).
//    busy falls the cycle after the last handshake; start_ready rises the same cycle.
//  Output hold: subkey, round_idx and last stay stable while subkey_valid=1 and subkey_ready=0.
//  Back-to-back: start is accepted the cycle start_ready=1. start while busy is ignored, with no
//    mode_err.
//  Mid-job reset: asynchronous reset clears everything immediately. No partial key is issued
//    after reset is released.
// CONFIGURATION
//  AES_KEYEXP_REVERSE_EN defined:
//    Adds input `reverse` (1 bit, sampled on start accept) and a 15x128 round-key store.
//    reverse=1: the full schedule is generated silently into the store, then keys are emitted
//      Nr..0 for decryption. round_idx counts down. last is asserted with round 0.
//      First valid arrives at E+4*(Nr+1)+1.
//    reverse=0: behaves as forward mode.
//  Not defined: no reverse port and no store; forward order only.
// TESTING
//  1. 128: key=2b7e1516_28aed2a6_abf71588_09cf4f3c, ready=1.
//     -> r1=a0fafe17_88542cb1_23a33939_2a6c7605; r10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with last=1.
//  2. 192: key=8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b.
//     -> r1=62f8ead2_522c6b7b_fe0c91f7_2402f5a5; r12=e98ba06f_448c773c_8ecc7204_01002202.
//  3. 256: key=603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4.
//     -> r2=9ba35411_8e6925af_a51a8b5f_2067fcde; r14=fe4890d1_e6188d0b_046df344_706c631e.
//  4. Test 1 with subkey_ready toggling randomly, held low 20 cycles at r3.
//     -> subkey stable while stalled; same 11 keys in order; no key lost or duplicated.
//  5. start with key_mode=11, and with 01 when SUPPORT_192=0.
//     -> mode_err=1 for one cycle; busy stays 0; no subkey_valid.
//  6. Reset asserted at r5 of a 256 job, then a new 128 job.
//     -> outputs at reset values immediately; new job matches test 1 exactly.

Source files
------------

// File: rtl/aes_key_expansion_multi.sv
// aes_key_expansion_multi
//   Multi-mode AES key schedule (AES-128/192/256 chosen per job by key_mode).
//   One 32-bit schedule word is produced per cycle through a single 4-byte
//   S-box. Words are gathered four at a time into 128-bit round keys, which
//   are streamed over a valid/ready handshake in round order 0..Nr.
//
//   Ports
//     clk, reset      rising-edge clock, asynchronous active-high reset
//     start           job request, accepted only while start_ready=1
//     start_ready     FSM idle
//     key_mode        00=128, 01=192, 10=256, 11=illegal (sampled on accept)
//     key             left-aligned cipher key (sampled on accept)
//     subkey          round key, w[4r] in [127:96]
//     subkey_valid    subkey/round_idx/last valid
//     subkey_ready    consumer accept
//     round_idx       round number of subkey
//     last            final round key of the job
//     busy            job in progress
//     mode_err        one-cycle pulse on start with an illegal/disabled mode
//
//   Parameters
//     SUPPORT_192, SUPPORT_256  0 makes that key_mode illegal
//
//   Optional feature macro: AES_KEYEXP_REVERSE_EN
//     Adds input reverse and a 15x128 round-key store. With reverse=1 the
//     schedule is built silently into the store and then emitted Nr..0.

module aes_key_expansion_multi #(
  parameter int SUPPORT_192 = 1,
  parameter int SUPPORT_256 = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         start_ready,
  input  logic [1:0]   key_mode,
  input  logic [255:0] key,
`ifdef AES_KEYEXP_REVERSE_EN
  input  logic         reverse,
`endif
  output logic [127:0] subkey,
  output logic         subkey_valid,
  input  logic         subkey_ready,
  output logic [3:0]   round_idx,
  output logic         last,
  output logic         busy,
  output logic         mode_err
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_EMIT, S_DRAIN} state_t;

  // AES S-box, byte 0x00 in the top 8 bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // msb of entry x sits at bit 8*(255-x)+7 == {~x, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state;
  logic [255:0]  key_q;
  logic [1:0]    mode_q;
  logic [5:0]    i_q;       // schedule word index
  logic [2:0]    kcnt;      // i mod Nk
  logic [7:0]    rcon;
  logic [31:0]   win [8];   // win[7] = w[i-1] ... win[0] = w[i-8]
  logic [31:0]   acc0, acc1, acc2;

`ifdef AES_KEYEXP_REVERSE_EN
  logic          rev_q;
  logic [3:0]    ptr;
  logic [3:0]    nr;
  logic [127:0]  store [15];
`endif

  logic [2:0]    nk_m1;
  logic [5:0]    last_i;
  logic [31:0]   back;
  logic [31:0]   key_word;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   new_word;
  logic [127:0]  round_key;
  logic          is_key;
  logic          mode_legal;
  logic          hs;
  logic          emit_direct;
  logic          slot_free;
  logic          gen_en;

  always_comb begin
    case (mode_q)
      2'b01:   begin nk_m1 = 3'd5; last_i = 6'd51; back = win[2]; end
      2'b10:   begin nk_m1 = 3'd7; last_i = 6'd59; back = win[0]; end
      default: begin nk_m1 = 3'd3; last_i = 6'd43; back = win[4]; end
    endcase
  end

`ifdef AES_KEYEXP_REVERSE_EN
  always_comb begin
    case (mode_q)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end
  assign emit_direct = !rev_q;
`else
  assign emit_direct = 1'b1;
`endif

  always_comb begin
    is_key   = (i_q[5:3] == 3'd0) && (i_q[2:0] <= nk_m1);
    // key word j has its msb at 255-32j == {~j, 5'b11111}
    key_word = key_q[{~i_q[2:0], 5'b11111} -: 32];
    sub_in   = (kcnt == 3'd0) ? {win[7][23:0], win[7][31:24]} : win[7];
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (kcnt == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (mode_q == 2'b10 && kcnt == 3'd4)
      temp = sub_out;
    else
      temp = win[7];
    new_word  = is_key ? key_word : (back ^ temp);
    round_key = {acc0, acc1, acc2, new_word};
  end

  assign hs         = subkey_valid & subkey_ready;
  assign mode_legal = (key_mode == 2'b00) ||
                      (key_mode == 2'b01 && SUPPORT_192 != 0) ||
                      (key_mode == 2'b10 && SUPPORT_256 != 0);
  // The 4th word of a round needs the output register to be free (or
  // freeing this cycle); otherwise the whole generator holds.
  assign slot_free  = (i_q[1:0] != 2'd3) || !emit_direct || !subkey_valid || subkey_ready;
  assign gen_en     = (state == S_GEN) && slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
      mode_err     <= 1'b0;
      key_q        <= '0;
      mode_q       <= 2'b00;
      i_q          <= '0;
      kcnt         <= '0;
      rcon         <= 8'h01;
      for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
      acc0         <= '0;
      acc1         <= '0;
      acc2         <= '0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      round_idx    <= '0;
      last         <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
      rev_q        <= 1'b0;
      ptr          <= '0;
      for (int unsigned k = 0; k < 15; k++) store[k] <= '0;
`endif
    end else begin
      mode_err <= 1'b0;
      if (hs) subkey_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode_legal) begin
              key_q       <= key;
              mode_q      <= key_mode;
              i_q         <= '0;
              kcnt        <= '0;
              rcon        <= 8'h01;
              state       <= S_GEN;
              start_ready <= 1'b0;
              busy        <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
              rev_q       <= reverse;
`endif
            end else begin
              mode_err <= 1'b1;
            end
          end
        end

        S_GEN: begin
          if (gen_en) begin
            for (int unsigned k = 0; k < 7; k++) win[k] <= win[k + 1];
            win[7] <= new_word;
            i_q    <= i_q + 6'd1;
            kcnt   <= (kcnt == nk_m1) ? 3'd0 : kcnt + 3'd1;
            if (kcnt == 3'd0 && !is_key) rcon <= xtime(rcon);
            case (i_q[1:0])
              2'd0: acc0 <= new_word;
              2'd1: acc1 <= new_word;
              2'd2: acc2 <= new_word;
              default: begin
                if (emit_direct) begin
                  subkey       <= round_key;
                  subkey_valid <= 1'b1;
                  round_idx    <= i_q[5:2];
                  last         <= (i_q == last_i);
                end
`ifdef AES_KEYEXP_REVERSE_EN
                else begin
                  store[i_q[5:2]] <= round_key;
                end
`endif
              end
            endcase
            if (i_q == last_i) begin
              state <= emit_direct ? S_DRAIN : S_EMIT;
`ifdef AES_KEYEXP_REVERSE_EN
              ptr   <= nr;
`endif
            end
          end
        end

`ifdef AES_KEYEXP_REVERSE_EN
        S_EMIT: begin
          if (!subkey_valid || hs) begin
            subkey       <= store[ptr];
            subkey_valid <= 1'b1;
            round_idx    <= ptr;
            last         <= (ptr == 4'd0);
            if (ptr == 4'd0) state <= S_DRAIN;
            else             ptr   <= ptr - 4'd1;
          end
        end
`endif

        S_DRAIN: begin
          if (hs && last) begin
            state       <= S_IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion_multi.sv
// Testbench for aes_key_expansion_multi: randomized and FIPS-197 jobs checked
// against a behavioural key-schedule model (S-box built from GF(2^8) inverse
// plus affine map, Rcon as powers of x).

module tb_aes_key_expansion_multi;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, start_b;
  logic         start_ready, start_ready_b;
  logic [1:0]   key_mode, key_mode_b;
  logic [255:0] key;
  logic [127:0] subkey, subkey_b;
  logic         subkey_valid, subkey_valid_b;
  logic         subkey_ready;
  logic [3:0]   round_idx, round_idx_b;
  logic         last, last_b, busy, busy_b, mode_err, mode_err_b;
`ifdef AES_KEYEXP_REVERSE_EN
  logic         reverse = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_key_expansion_multi #(.SUPPORT_192(1), .SUPPORT_256(1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .key_mode(key_mode), .key(key),
`ifdef AES_KEYEXP_REVERSE_EN
    .reverse(reverse),
`endif
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round_idx(round_idx), .last(last), .busy(busy), .mode_err(mode_err)
  );

  aes_key_expansion_multi #(.SUPPORT_192(0), .SUPPORT_256(1)) dut_no192 (
    .clk(clk), .reset(reset), .start(start_b), .start_ready(start_ready_b),
    .key_mode(key_mode_b), .key(key),
`ifdef AES_KEYEXP_REVERSE_EN
    .reverse(1'b0),
`endif
    .subkey(subkey_b), .subkey_valid(subkey_valid_b), .subkey_ready(1'b1),
    .round_idx(round_idx_b), .last(last_b), .busy(busy_b), .mode_err(mode_err_b)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  int           exp_nr;

  logic [127:0] got_key [$];
  logic [3:0]   got_idx [$];
  logic         got_last [$];
  int           first_valid, last_valid, spacing_err, stall_viol, merr_seen, timed_out;
  logic         post_busy, post_sr, busy_after_start;
  bit           hold_seen;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gf_mul(inv, x[7:0]);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // FIPS-197 key expansion written directly from the word rule.
  task automatic expand(input logic [255:0] k, input logic [1:0] m);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [255:0] sh;
    logic [7:0]   rc;
    int nk;
    nk = 4 + 2 * int'(m);
    exp_nr = nk + 6;
    for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
      if (i < nk) begin
        sh = k << (32 * i);
        w[i] = sh[255:224];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int j = 1; j < i / nk; j++) rc = gf_mul(rc, 8'h02);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= exp_nr; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // rmode: 0 ready=1, 1 random ready, 2 random + 20-cycle hold at round 3,
  //        3 ready=1 with an illegal start pulse mid-job
  task automatic run_job(input logic [255:0] k, input logic [1:0] m, input int rmode);
    int cyc = 0;
    int hold = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [127:0] pk = '0;
    logic [3:0]   pi = '0;
    logic         pl = 1'b0;
    got_key.delete(); got_idx.delete(); got_last.delete();
    first_valid = -1; last_valid = -1; spacing_err = 0; stall_viol = 0;
    merr_seen = 0; timed_out = 1; hold_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; key = k; key_mode = m;
    subkey_ready = (rmode == 1 || rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key = ~k;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 0) busy_after_start = busy;
      if (mode_err) merr_seen++;
      if (done) begin
        post_busy = busy; post_sr = start_ready; timed_out = 0;
        break;
      end
      if (prev_stall && (!subkey_valid || subkey !== pk || round_idx !== pi || last !== pl))
        stall_viol++;
      if (subkey_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (last && last_valid < 0) last_valid = cyc;
        if (cyc % 4 != 0) spacing_err++;
        if (subkey_ready) begin
          got_key.push_back(subkey); got_idx.push_back(round_idx); got_last.push_back(last);
          if (last) done = 1;
        end
      end
      prev_stall = subkey_valid && !subkey_ready;
      pk = subkey; pi = round_idx; pl = last;
      @(posedge clk); #1;
      cyc++;
      start = (rmode == 3 && cyc == 10);
      if (start) key_mode = 2'b11;
      if (rmode == 2 && !hold_seen && subkey_valid && round_idx == 4'd3) begin
        hold_seen = 1; hold = 20;
      end
      if (hold > 0) begin
        subkey_ready = 1'b0; hold--;
      end else if (rmode == 1 || rmode == 2) begin
        subkey_ready = 1'($urandom_range(0, 1));
      end else begin
        subkey_ready = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_forward(input logic [255:0] k, input logic [1:0] m, input int rmode);
    logic [3:0] ri;
    expand(k, m);
    run_job(k, m, rmode);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL job_timeout: mode %0d timed out", m); end
    checks++; if (busy_after_start !== 1'b1) begin failures++; $display("FAIL busy_on_start: got %b want 1", busy_after_start); end
    checks++; if (got_key.size() != exp_nr + 1) begin failures++; $display("FAIL key_count: got %0d want %0d", got_key.size(), exp_nr + 1); end
    for (int r = 0; r < got_key.size() && r <= exp_nr; r++) begin
      ri = r[3:0];
      checks++;
      if ({got_key[r], got_idx[r], got_last[r]} !== {exp_rk[r], ri, r == exp_nr}) begin
        failures++;
        $display("FAIL round_key[%0d]: got %h idx %0d last %b want %h idx %0d last %b",
                 r, got_key[r], got_idx[r], got_last[r], exp_rk[r], r, r == exp_nr);
      end
    end
    if (rmode == 0 || rmode == 3) begin
      checks++; if (first_valid != 4) begin failures++; $display("FAIL first_valid_cycle: got %0d want 4", first_valid); end
      checks++; if (last_valid != 4 * (exp_nr + 1)) begin failures++; $display("FAIL last_valid_cycle: got %0d want %0d", last_valid, 4 * (exp_nr + 1)); end
      checks++; if (spacing_err != 0) begin failures++; $display("FAIL key_spacing: %0d off-grid valid cycles want 0", spacing_err); end
    end
    checks++; if (merr_seen != 0) begin failures++; $display("FAIL mode_err_in_job: got %0d pulses want 0", merr_seen); end
    checks++; if ({post_busy, post_sr} !== 2'b01) begin failures++; $display("FAIL post_job busy/start_ready: got %b%b want 01", post_busy, post_sr); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({start_ready, busy, subkey_valid, last, mode_err, round_idx, subkey} !== {1'b1, 4'b0, 4'b0, 128'b0}) begin
      failures++;
      $display("FAIL reset_outputs: sr %b busy %b valid %b last %b merr %b idx %0d key %h want sr=1 rest 0",
               start_ready, busy, subkey_valid, last, mode_err, round_idx, subkey);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if ({start_ready, busy, subkey_valid} !== 3'b100) begin failures++; $display("FAIL idle_after_reset: got %b want 100", {start_ready, busy, subkey_valid}); end
  endtask

  task automatic test_fips128();
    test_forward(K128, 2'b00, 0);
    if (got_key.size() == 11) begin
      checks++; if (got_key[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL fips128_r1: got %h", got_key[1]); end
      checks++; if ({got_key[10], got_last[10]} !== {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1}) begin failures++; $display("FAIL fips128_r10: got %h last %b", got_key[10], got_last[10]); end
    end
  endtask

  task automatic test_fips192();
    test_forward(K192, 2'b01, 0);
    if (got_key.size() == 13) begin
      checks++; if (got_key[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin failures++; $display("FAIL fips192_r1: got %h", got_key[1]); end
      checks++; if (got_key[12] !== 128'he98ba06f448c773c8ecc720401002202) begin failures++; $display("FAIL fips192_r12: got %h", got_key[12]); end
    end
  endtask

  task automatic test_fips256();
    test_forward(K256, 2'b10, 0);
    if (got_key.size() == 15) begin
      checks++; if (got_key[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin failures++; $display("FAIL fips256_r2: got %h", got_key[2]); end
      checks++; if (got_key[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL fips256_r14: got %h", got_key[14]); end
    end
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic [1:0]   m;
    for (int j = 0; j < 6; j++) begin
      for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
      m = 2'($urandom_range(0, 2));
      test_forward(k, m, j % 2);
    end
  endtask

  task automatic test_stall();
    test_forward(K128, 2'b00, 2);
    checks++; if (!hold_seen) begin failures++; $display("FAIL stall_hold_reached: got 0 want 1"); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stability: %0d changes while stalled want 0", stall_viol); end
  endtask

  task automatic test_illegal();
    int valids = 0;
    @(posedge clk); #1;
    start = 1'b1; key_mode = 2'b11; start_b = 1'b1; key_mode_b = 2'b01;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    @(negedge clk);
    checks++; if ({mode_err, busy, start_ready} !== 3'b101) begin failures++; $display("FAIL illegal11_pulse: merr/busy/sr got %b want 101", {mode_err, busy, start_ready}); end
    checks++; if ({mode_err_b, busy_b, start_ready_b} !== 3'b101) begin failures++; $display("FAIL disabled192_pulse: merr/busy/sr got %b want 101", {mode_err_b, busy_b, start_ready_b}); end
    @(negedge clk);
    checks++; if ({mode_err, mode_err_b} !== 2'b00) begin failures++; $display("FAIL mode_err_width: got %b want 00", {mode_err, mode_err_b}); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (subkey_valid || subkey_valid_b || busy || busy_b) valids++;
    end
    checks++; if (valids != 0) begin failures++; $display("FAIL illegal_no_job: %0d active cycles want 0", valids); end
  endtask

  task automatic test_busy_start();
    test_forward(K256, 2'b10, 3);
  endtask

  task automatic test_back_to_back();
    int fv = -1;
    bool_done: begin end
    test_forward(K128, 2'b00, 0);
    expand(K192, 2'b01);
    start = 1'b1; key = K192; key_mode = 2'b01; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, start_ready} !== 2'b10) begin failures++; $display("FAIL b2b_accept: busy/sr got %b want 10", {busy, start_ready}); end
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (subkey_valid) begin fv = c; break; end
    end
    checks++; if (fv != 4) begin failures++; $display("FAIL b2b_first_valid: got %0d want 4", fv); end
    checks++; if (subkey !== exp_rk[0]) begin failures++; $display("FAIL b2b_round0: got %h want %h", subkey, exp_rk[0]); end
    fv = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (start_ready) begin fv = c; break; end
    end
    checks++; if (fv < 0) begin failures++; $display("FAIL b2b_drain: start_ready never returned"); end
  endtask

  task automatic test_midjob_reset();
    int found = 0;
    int valids = 0;
    expand(K256, 2'b10);
    @(posedge clk); #1;
    start = 1'b1; key = K256; key_mode = 2'b10; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (subkey_valid && round_idx == 4'd5) begin found = 1; break; end
    end
    checks++; if (found != 1 || subkey !== exp_rk[5]) begin failures++; $display("FAIL reset_job_r5: found %0d key %h want %h", found, subkey, exp_rk[5]); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({start_ready, busy, subkey_valid, last, mode_err, round_idx, subkey} !== {1'b1, 4'b0, 4'b0, 128'b0}) begin
      failures++;
      $display("FAIL midjob_reset_outputs: sr %b busy %b valid %b last %b idx %0d key %h want sr=1 rest 0",
               start_ready, busy, subkey_valid, last, round_idx, subkey);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (subkey_valid || busy) valids++;
    end
    checks++; if (valids != 0) begin failures++; $display("FAIL post_reset_quiet: %0d active cycles want 0", valids); end
    test_fips128();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_b = 1'b0; key_mode = 2'b00; key_mode_b = 2'b00;
    key = '0; subkey_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips128();
    test_fips192();
    test_fips256();
    test_random();
    test_stall();
    test_illegal();
    test_busy_start();
    test_back_to_back();
    test_midjob_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
